// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: EX-stage bypass selection, ID load-use detection,
// and a self-timed scoreboard of in-flight long-latency (mul/div) writes that
// stalls dependent, WAW-conflicting or structurally blocked instructions in ID.
module fwd_hazard_unit #(
    parameter int AW         = 5,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int SB_DEPTH   = 4,
    parameter int LAT_W      = 5,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC*AW-1:0]             ex_rs,
    input  logic [NUM_STAGES-1:0]             stg_valid,
    input  logic [NUM_STAGES-1:0]             stg_regWrite,
    input  logic [NUM_STAGES*AW-1:0]          stg_rd,
    input  logic                              stg0_isLoad,
    input  logic                              id_valid,
    input  logic [NUM_SRC*AW-1:0]             id_rs,
    input  logic [NUM_SRC-1:0]                id_rs_used,
    input  logic                              id_regWrite,
    input  logic [AW-1:0]                     id_rd,
    input  logic                              id_isLong,
    input  logic [LAT_W-1:0]                  id_lat,
    input  logic                              ex_isLoad,
    input  logic                              ex_valid,
    input  logic                              ex_regWrite,
    input  logic [AW-1:0]                     ex_rd,
    output logic [NUM_SRC*SEL_W-1:0]          fwd_sel,
    output logic                              stall,
    output logic                              sb_busy,
    output logic [$clog2(SB_DEPTH+1)-1:0]     sb_count,
    output logic [31:0]                       stall_cnt
);

    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    // stg0_isLoad is informational here: the load-use hazard is caught one
    // stage earlier (ID vs ID/EX), so a load never needs to forward from EX/MEM.
    logic unused_ok;
    assign unused_ok = stg0_isLoad;

    logic [SB_DEPTH-1:0] sb_valid;
    logic [SB_DEPTH-1:0] raw_hit;
    logic [SB_DEPTH-1:0] waw_hit;
    logic [SB_DEPTH-1:0] alloc_oh;
    logic [NUM_SRC-1:0]  lu_hit;
    logic [LAT_W-1:0]    lat_eff;
    logic                lu;
    logic                raw;
    logic                waw;
    logic                full;
    logic                do_alloc;
    logic [31:0]         stall_cnt_reg;

    genvar gi;

    // Per-operand bypass select and load-use match
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [AW-1:0]    rs;
            logic [SEL_W-1:0] sel;
            assign rs = ex_rs[gi*AW +: AW];

            // Walk stages oldest to youngest so the youngest match overrides
            always_comb begin
                sel = '0;
                for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                    if (stg_valid[k] && stg_regWrite[k] &&
                        stg_rd[k*AW +: AW] != '0 && stg_rd[k*AW +: AW] == rs)
                        sel = SEL_W'(k + 1);
                end
            end

            assign fwd_sel[gi*SEL_W +: SEL_W] = sel;
            assign lu_hit[gi] = id_rs_used[gi] && (ex_rd == id_rs[gi*AW +: AW]);
        end
    endgenerate

    assign lu = id_valid && ex_valid && ex_isLoad && ex_regWrite &&
                (ex_rd != '0) && (|lu_hit);

    assign lat_eff  = (id_lat == '0) ? LAT_W'(1) : id_lat;
    assign raw      = |raw_hit;
    assign waw      = id_regWrite && (|waw_hit);
    assign full     = id_isLong && (&sb_valid);
    assign stall    = id_valid && (lu || raw || waw || full);
    assign do_alloc = id_valid && !stall && id_isLong && id_regWrite && (id_rd != '0);

    // Pick the lowest-index free scoreboard slot
    always_comb begin
        logic found;
        alloc_oh = '0;
        found    = 1'b0;
        for (int j = 0; j < SB_DEPTH; j++) begin
            if (!sb_valid[j] && !found) begin
                alloc_oh[j] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Scoreboard entries: allocate into a free slot or count down to retirement
    generate
        for (gi = 0; gi < SB_DEPTH; gi++) begin : g_sb
            logic             valid_reg;
            logic [AW-1:0]    rd_reg;
            logic [LAT_W-1:0] cnt_reg;
            logic [NUM_SRC-1:0] rs_match;

            // Entry state; retirement at cnt==1 coincides with the long-unit write-back
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    rd_reg    <= '0;
                    cnt_reg   <= '0;
                end else if (valid_reg) begin
                    if (cnt_reg > LAT_W'(1)) begin
                        cnt_reg <= cnt_reg - LAT_W'(1);
                    end else begin
                        valid_reg <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end else if (do_alloc && alloc_oh[gi]) begin
                    valid_reg <= 1'b1;
                    rd_reg    <= id_rd;
                    cnt_reg   <= lat_eff;
                end
            end

            // Source-operand comparison against this entry's destination
            always_comb begin
                rs_match = '0;
                for (int s = 0; s < NUM_SRC; s++)
                    rs_match[s] = id_rs_used[s] && (id_rs[s*AW +: AW] == rd_reg);
            end

            assign sb_valid[gi] = valid_reg;
            assign raw_hit[gi]  = valid_reg && (|rs_match);
            assign waw_hit[gi]  = valid_reg && (rd_reg == id_rd);
        end
    endgenerate

    // Population count of occupied slots
    always_comb begin
        sb_count = '0;
        for (int j = 0; j < SB_DEPTH; j++)
            sb_count = sb_count + CNT_W'(sb_valid[j]);
    end

    assign sb_busy = (sb_count != '0);

    // Saturating stall-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (stall && stall_cnt_reg != 32'hFFFF_FFFF)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use,
// long-op RAW/WAW, scoreboard full and asynchronous reset mid-countdown.
module tb_fwd_hazard_unit;

    localparam int AW = 5, NUM_SRC = 2, NUM_STAGES = 2, SB_DEPTH = 4, LAT_W = 5;
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic [NUM_SRC*AW-1:0]      ex_rs = '0;
    logic [NUM_STAGES-1:0]      stg_valid = '0;
    logic [NUM_STAGES-1:0]      stg_regWrite = '0;
    logic [NUM_STAGES*AW-1:0]   stg_rd = '0;
    logic                       stg0_isLoad = 1'b0;
    logic                       id_valid = 1'b0;
    logic [NUM_SRC*AW-1:0]      id_rs = '0;
    logic [NUM_SRC-1:0]         id_rs_used = '0;
    logic                       id_regWrite = 1'b0;
    logic [AW-1:0]              id_rd = '0;
    logic                       id_isLong = 1'b0;
    logic [LAT_W-1:0]           id_lat = '0;
    logic                       ex_isLoad = 1'b0;
    logic                       ex_valid = 1'b0;
    logic                       ex_regWrite = 1'b0;
    logic [AW-1:0]              ex_rd = '0;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       stall;
    logic                       sb_busy;
    logic [2:0]                 sb_count;
    logic [31:0]                stall_cnt;

    int total = 0;
    int bad   = 0;

    fwd_hazard_unit #(
        .AW(AW), .NUM_SRC(NUM_SRC), .NUM_STAGES(NUM_STAGES),
        .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst(rst), .ex_rs(ex_rs), .stg_valid(stg_valid),
        .stg_regWrite(stg_regWrite), .stg_rd(stg_rd), .stg0_isLoad(stg0_isLoad),
        .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_regWrite(id_regWrite), .id_rd(id_rd), .id_isLong(id_isLong),
        .id_lat(id_lat), .ex_isLoad(ex_isLoad), .ex_valid(ex_valid),
        .ex_regWrite(ex_regWrite), .ex_rd(ex_rd), .fwd_sel(fwd_sel),
        .stall(stall), .sb_busy(sb_busy), .sb_count(sb_count), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle ID: nothing valid, nothing read
    task automatic id_idle();
        id_valid = 0; id_isLong = 0; id_regWrite = 0; id_rd = 0;
        id_lat = 0; id_rs = '0; id_rs_used = '0;
    endtask

    // Present an instruction in ID
    task automatic id_set(input logic lng, input logic wr, input logic [AW-1:0] rd,
                          input logic [LAT_W-1:0] lat, input logic [AW-1:0] rs1,
                          input logic [NUM_SRC-1:0] used);
        id_valid = 1; id_isLong = lng; id_regWrite = wr; id_rd = rd;
        id_lat = lat; id_rs = {rs1, 5'd0}; id_rs_used = used;
    endtask

    initial begin
        // ---- reset ----
        #2 rst = 1;
        #4;
        $display("reset asserted");
        chk("rst_sb_count", 32'(sb_count), 32'd0);
        chk("rst_sb_busy", 32'(sb_busy), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        #6 rst = 0;
        tick();

        // ---- forwarding priority ----
        ex_rs = {5'd0, 5'd5}; stg_valid = 2'b11; stg_regWrite = 2'b11; stg_rd = {5'd5, 5'd5};
        #3 chk("fwd_both_stages", 32'(fwd_sel), 32'h1);
        $display("fwd: rs0=5 both stages write x5 -> sel=%0h", fwd_sel);
        stg_regWrite = 2'b10;
        #3 chk("fwd_stage1_only", 32'(fwd_sel), 32'h2);
        $display("fwd: stage0 no write -> sel=%0h", fwd_sel);
        ex_rs = {5'd5, 5'd5};
        #3 chk("fwd_two_operands", 32'(fwd_sel), 32'hA);
        $display("fwd: both operands x5 -> sel=%0h", fwd_sel);
        ex_rs = {5'd6, 5'd0}; stg_valid = 2'b10; stg_regWrite = 2'b11; stg_rd = {5'd6, 5'd6};
        #3 chk("fwd_stage0_invalid", 32'(fwd_sel), 32'h8);
        $display("fwd: stage0 invalid -> sel=%0h", fwd_sel);
        ex_rs = '0; stg_valid = 2'b11; stg_regWrite = 2'b11; stg_rd = '0;
        #3 chk("fwd_x0", 32'(fwd_sel), 32'h0);
        $display("fwd: x0 -> sel=%0h", fwd_sel);
        stg_valid = '0; stg_regWrite = '0;
        tick();

        // ---- load-use ----
        ex_valid = 1; ex_isLoad = 1; ex_regWrite = 1; ex_rd = 7;
        id_set(0, 1, 5'd8, 0, 5'd7, 2'b10);
        #3 chk("lu_stall", 32'(stall), 32'd1);
        $display("load-use: x7 -> stall=%0b", stall);
        tick();
        ex_valid = 0; ex_isLoad = 0; ex_regWrite = 0; ex_rd = 0;
        #3 chk("lu_release", 32'(stall), 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        $display("load-use bubble: stall=%0b stall_cnt=%0d", stall, stall_cnt);
        ex_valid = 1; ex_isLoad = 1; ex_regWrite = 1; ex_rd = 7; id_rs_used = 2'b01;
        #3 chk("lu_unused", 32'(stall), 32'd0);
        $display("load-use operand unused: stall=%0b", stall);
        tick();
        ex_valid = 0; ex_isLoad = 0; ex_regWrite = 0; ex_rd = 0;
        id_idle();

        // ---- long RAW: rd=3 lat=4 ----
        id_set(1, 1, 5'd3, 5'd4, 5'd0, 2'b00);
        #3 chk("raw_issue", 32'(stall), 32'd0);
        tick();
        id_set(0, 1, 5'd12, 0, 5'd3, 2'b10);
        for (int c = 1; c <= 4; c++) begin
            #3 chk("raw_stall", 32'(stall), 32'd1);
            $display("long RAW t+%0d: stall=%0b sb_count=%0d", c, stall, sb_count);
            tick();
        end
        #3 chk("raw_release", 32'(stall), 32'd0);
        chk("raw_sb_busy", 32'(sb_busy), 32'd0);
        chk("raw_stall_cnt", stall_cnt, 32'd5);
        $display("long RAW t+5: stall=%0b stall_cnt=%0d", stall, stall_cnt);
        tick();

        // ---- WAW with lat=0 ----
        id_set(1, 1, 5'd9, 5'd0, 5'd0, 2'b00);
        #3 chk("waw_issue", 32'(stall), 32'd0);
        tick();
        id_set(0, 1, 5'd9, 0, 5'd0, 2'b00);
        #3 chk("waw_stall", 32'(stall), 32'd1);
        chk("waw_sb_count", 32'(sb_count), 32'd1);
        $display("WAW x9: stall=%0b sb_count=%0d", stall, sb_count);
        tick();
        #3 chk("waw_release", 32'(stall), 32'd0);
        chk("waw_sb_count0", 32'(sb_count), 32'd0);
        chk("waw_stall_cnt", stall_cnt, 32'd6);
        $display("WAW next: stall=%0b stall_cnt=%0d", stall, stall_cnt);
        tick();

        // ---- scoreboard full ----
        for (int r = 1; r <= 4; r++) begin
            id_set(1, 1, 5'(r), 5'd8, 5'd0, 2'b00);
            #3 chk("full_issue", 32'(stall), 32'd0);
            $display("full: issue x%0d stall=%0b", r, stall);
            tick();
        end
        id_set(1, 1, 5'd10, 5'd2, 5'd0, 2'b00);
        for (int c = 4; c <= 8; c++) begin
            #3 chk("full_stall", 32'(stall), 32'd1);
            chk("full_count", 32'(sb_count), 32'd4);
            $display("full f+%0d: stall=%0b sb_count=%0d", c, stall, sb_count);
            tick();
        end
        #3 chk("full_alloc", 32'(stall), 32'd0);
        chk("full_count_after_retire", 32'(sb_count), 32'd3);
        $display("full f+9: stall=%0b sb_count=%0d", stall, sb_count);
        tick();
        id_set(0, 0, 5'd0, 0, 5'd10, 2'b10);
        #3 chk("full_new_entry_raw", 32'(stall), 32'd1);
        chk("full_count_f10", 32'(sb_count), 32'd3);
        chk("full_stall_cnt", stall_cnt, 32'd11);
        $display("full f+10: stall=%0b sb_count=%0d stall_cnt=%0d", stall, sb_count, stall_cnt);

        // ---- reset mid-countdown ----
        #1 rst = 1;
        #1;
        chk("mid_rst_busy", 32'(sb_busy), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_count", 32'(sb_count), 32'd0);
        chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
        $display("mid reset: sb_busy=%0b stall=%0b", sb_busy, stall);
        tick();
        #2 rst = 0;
        #1 chk("post_rst_stall", 32'(stall), 32'd0);
        tick();
        #1 chk("post_rst_stall_cnt", stall_cnt, 32'd0);
        chk("post_rst_count", 32'(sb_count), 32'd0);
        $display("after reset: stall=%0b stall_cnt=%0d", stall, stall_cnt);
        id_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the RISC-V pipeline, covering N source operands and M forwarding stages. It combines three jobs: per-operand bypass selection for the EX stage, load-use stall detection for ID, and a self-timed scoreboard of in-flight long-latency writes (mul/div). The scoreboard stalls dependent, WAW-conflicting or structurally blocked instructions in ID. It sits between the ID/EX pipeline registers and the later stage registers, and drives the EX operand muxes and the ID/IF stall enable.

## Interface

Parameters:
- AW, 5: register address width
- NUM_SRC, 2: source operands per instruction
- NUM_STAGES, 2: forwarding stages, index 0 = EX/MEM (youngest), 1 = MEM/WB, ...
- SB_DEPTH, 4: scoreboard entries
- LAT_W, 5: long-op latency field width
- SEL_W, $clog2(NUM_STAGES+1): forward-select width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ex_rs  in  NUM_SRC*AW  EX-stage source addresses; operand i = bits [i*AW +: AW]
- stg_valid  in  NUM_STAGES  per-stage valid
- stg_regWrite  in  NUM_STAGES  per-stage register write
- stg_rd  in  NUM_STAGES*AW  per-stage destination
- stg0_isLoad  in  1  EX/MEM instruction is a load (load-use check)
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  NUM_SRC*AW  ID source addresses
- id_rs_used  in  NUM_SRC  operand i is actually read
- id_regWrite  in  1  ID instruction writes rd
- id_rd  in  AW  ID destination
- id_isLong  in  1  ID instruction goes to the long-latency unit
- id_lat  in  LAT_W  long-op latency in cycles; 0 is treated as 1
- ex_isLoad  in  1  ID/EX instruction is a load
- ex_valid, ex_regWrite  in  1  ID/EX qualifiers
- ex_rd  in  AW  ID/EX destination
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k-1
- stall  out  1  hold IF/ID, bubble into EX
- sb_busy  out  1  any scoreboard entry valid
- sb_count  out  $clog2(SB_DEPTH+1)  number of valid entries
- stall_cnt  out  32  saturating count of stall cycles

## Operation

- **Forwarding (combinational):** fwd_sel[i] = k+1 for the lowest k with stg_valid[k] && stg_regWrite[k] && stg_rd[k]!=0 && stg_rd[k]==ex_rs[i]; otherwise 0. Lower stage index wins. ex_rs[i]==0 always gives 0.
- **Load-use:** lu = id_valid && ex_valid && ex_isLoad && ex_regWrite && ex_rd!=0 && (ex_rd==id_rs[i] && id_rs_used[i]) for any i.
- **Scoreboard entry:** {valid, rd[AW], cnt[LAT_W]}.
- **RAW hit:** raw = any valid entry with rd==id_rs[i] && id_rs_used[i].
- **WAW hit:** waw = id_regWrite && any valid entry with rd==id_rd.
- **Full:** full = id_isLong && all SB_DEPTH entries valid. Fullness is evaluated on the current valid bits; an entry retiring this cycle does not free a slot this cycle.
- **Stall:** stall = id_valid && (lu || raw || waw || full).
- **Allocate:** on id_valid && !stall && id_isLong && id_regWrite && id_rd!=0, the lowest-index free entry is loaded with rd=id_rd and cnt=max(id_lat,1). No allocation when rd=0.
- **Countdown:** each cycle every valid entry with cnt>1 decrements. An entry with cnt==1 clears valid; the long unit writes the register file on that same edge. Allocation into a slot and retirement of a different slot may occur on the same edge.
- **stall_cnt:** +1 each cycle stall==1; saturates at 0xFFFF_FFFF.
- **sb_count / sb_busy:** popcount of valid bits / sb_count!=0.

## Timing

- fwd_sel, stall: combinational, same cycle as inputs and current state.
- Allocation is visible to raw/waw/full from the cycle after issue.
- An op issued at cycle t with lat L holds its entry for cycles t+1..t+L. A dependent instruction in ID stalls through t+L and proceeds at t+L+1, reading the updated register file.
- Reset (async, any time, including mid-countdown): all entries invalid, cnt=0, stall_cnt=0, sb_busy=0, sb_count=0. Outputs are then purely input-derived: fwd_sel=0 and stall=0 unless load-use is present. In-flight long ops are discarded.
- The scoreboard does not depend on stall/flush of later stages; allocated entries always count down.

## Test plan

- **Forward priority:** ex_rs[0]=5, stage0 and stage1 both write rd=5 -> fwd_sel[0]=1. Drop stage0 regWrite -> 2. Set rd=0 everywhere with ex_rs[0]=0 -> 0.
- **Load-use:** ex_isLoad, ex_rd=7, id_rs[1]=7 used -> stall=1 for exactly one cycle. Same with id_rs_used[1]=0 -> stall=0.
- **Long RAW:** issue long rd=3, lat=4 at t; next instruction reads x3 -> stall at t+1..t+4, released at t+5; stall_cnt +=4.
- **WAW and lat=0:** issue rd=9, lat=0 -> entry lives 1 cycle. A second writer to x9 in the following cycle stalls exactly 1 cycle.
- **Full:** 4 long ops (rd=1..4, lat=8) back-to-back -> sb_count=4 and a 5th long op stalls. In the cycle entry 0 retires, the 5th still stalls; it is allocated the next cycle.
- **Reset mid-countdown:** assert rst with 2 entries active -> sb_busy=0 and stall=0 immediately. After release, a dependent instruction proceeds without stall.
